// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the chunked borrow-lookahead subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_chunks(input int w, input int c);
    return w / c;
  endfunction

  // A single-chunk word still needs a one-bit index register.
  function automatic int idx_width(input int w, input int c);
    int n;
    n = w / c;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/borrow_lookahead_subtractor_if.sv
// Operand/result handshake bundle for the subtractor, plus the exposed FSM state.
interface borrow_lookahead_subtractor_if #(
  parameter int W = 16
);
  // Both sides use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid never waits on ready.
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           bin;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   diff;
  logic           bout;
  logic           ovf;
  logic           busy;
  sub_pkg::state_t state;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, busy, state
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, busy, state
  );
endinterface

// File: rtl/borrow_lookahead_unit.sv
// Combinational C-bit borrow-lookahead chunk: d = a - b - bin with borrow-out.
module borrow_lookahead_unit #(
  parameter int C = 4
) (
  input  logic         bin,
  input  logic [C-1:0] a_chunk,
  input  logic [C-1:0] b_chunk,
  output logic [C-1:0] d_chunk,
  output logic         bout_chunk
);

  logic [C-1:0] g;
  logic [C-1:0] p;
  logic [C:0]   br;

  assign br[0] = bin;

  // g: this bit borrows on its own; p: an incoming borrow passes through.
  for (genvar i = 0; i < C; i++) begin : g_bit
    assign g[i]      = ~a_chunk[i] & b_chunk[i];
    assign p[i]      = ~(a_chunk[i] ^ b_chunk[i]);
    assign br[i+1]   = g[i] | (p[i] & br[i]);
    assign d_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ br[i];
  end

  assign bout_chunk = br[C];

endmodule

// File: rtl/borrow_lookahead_subtractor.sv
// Multi-cycle subtractor: one C-bit lookahead chunk per cycle, LSB chunk first,
// with a registered borrow linking chunks.
module borrow_lookahead_subtractor
  import sub_pkg::*;
#(
  parameter int W = 16,
  parameter int C = 4
) (
  input  logic clk,
  input  logic rst,
  borrow_lookahead_subtractor_if.slave s
);

  localparam int N  = num_chunks(W, C);
  localparam int IW = idx_width(W, C);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    a_q, b_q, diff_q;
  logic            br_q, bout_q, ovf_q;
  logic [C-1:0]    a_chunk, b_chunk, d_chunk;
  logic            bout_chunk;
  logic            accept, last;
  int              base;

  assign base    = int'(idx_q) * C;
  assign a_chunk = a_q[base +: C];
  assign b_chunk = b_q[base +: C];
  assign last    = (idx_q == IW'(N - 1));
  assign accept  = s.in_valid && s.in_ready;

  borrow_lookahead_unit #(.C(C)) u_blu (
    .bin        (br_q),
    .a_chunk    (a_chunk),
    .b_chunk    (b_chunk),
    .d_chunk    (d_chunk),
    .bout_chunk (bout_chunk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (s.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      br_q   <= 1'b0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      idx_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q   <= s.a;
            b_q   <= s.b;
            br_q  <= s.bin;
            idx_q <= '0;
          end
        end
        RUN: begin
          diff_q[base +: C] <= d_chunk;
          br_q              <= bout_chunk;
          if (last) begin
            bout_q <= bout_chunk;
            // The MSB chunk is being written now, so its top bit is the result sign.
            ovf_q  <= (a_q[W-1] != b_q[W-1]) && (d_chunk[C-1] != a_q[W-1]);
            idx_q  <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s.in_ready  = (state_q == IDLE) && !rst;
  assign s.out_valid = (state_q == DONE);
  assign s.busy      = (state_q != IDLE);
  assign s.diff      = diff_q;
  assign s.bout      = bout_q;
  assign s.ovf       = ovf_q;
  assign s.state     = state_q;

endmodule

// File: tb/tb_borrow_lookahead_subtractor.sv
// Directed bench for borrow_lookahead_subtractor at W=16, C=4.
module tb_borrow_lookahead_subtractor;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  borrow_lookahead_subtractor_if #(.W(16)) bus ();

  borrow_lookahead_subtractor #(.W(16), .C(4)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, take the acceptance edge, then time the latency and check the result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input logic [15:0] exp_d,
                        input logic exp_bo, input logic exp_ov);
    int cycles;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    bus.in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.a        = $urandom_range(0, 16'hFFFF);
    bus.b        = $urandom_range(0, 16'hFFFF);
    bus.bin      = 1'($urandom_range(0, 1));
    cycles = 0;
    for (int k = 0; k < 20 && !bus.out_valid; k++) begin
      tick();
      cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'd4);
    check({tag, "_diff"}, 32'(bus.diff), 32'(exp_d));
    check({tag, "_bout"}, 32'(bus.bout), 32'(exp_bo));
    check({tag, "_ovf"},  32'(bus.ovf),  32'(exp_ov));
  endtask

  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_out_valid_low"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready_high"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    passed        = 0;
    total         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;

    #2;
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff",      32'(bus.diff),      32'd0);
    check("rst_bout",      32'(bus.bout),      32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    run_op("basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    release_out("basic");
    run_op("ripple",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    release_out("ripple");
    run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    release_out("ovf_neg");
    run_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    release_out("ovf_pos");
    run_op("bin_eq",  16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    release_out("bin_eq");

    // Backpressure: hold the result while new operands are offered.
    run_op("bp", 16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.a        = $urandom_range(0, 16'hFFFF);
      bus.b        = $urandom_range(0, 16'hFFFF);
      bus.bin      = 1'($urandom_range(0, 1));
      tick();
      check("bp_hold_diff",      32'(bus.diff),      32'h9999);
      check("bp_hold_bout",      32'(bus.bout),      32'd0);
      check("bp_hold_ovf",       32'(bus.ovf),       32'd0);
      check("bp_hold_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.a   = 16'h00FF;
    bus.b   = 16'h0F00;
    bus.bin = 1'b1;
    release_out("bp");
    run_op("bp_next", 16'h00FF, 16'h0F00, 1'b1, 16'hF1FE, 1'b1, 1'b0);
    release_out("bp_next");

    // Asynchronous reset during the second RUN cycle.
    bus.a        = 16'hFFFF;
    bus.b        = 16'h0001;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("mid_busy_before", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy",      32'(bus.busy),      32'd0);
    check("mid_rst_diff",      32'(bus.diff),      32'd0);
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      seen = seen | bus.out_valid;
    end
    check("post_rst_no_spurious", 32'(seen), 32'd0);
    run_op("fresh", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0);
    release_out("fresh");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no end expected end before 50000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/borrow_lookahead_subtractor.md
Name: borrow_lookahead_subtractor

Overview:
- Multi-cycle word subtractor: diff = a - b - bin, processed C bits per cycle, least-significant chunk first.
- Each chunk uses a combinational borrow-lookahead chain, the subtraction counterpart of the team's carry-lookahead adder.
- A registered borrow links consecutive chunks.
- Sits in the datapath ALU next to the adder. Uses valid/ready handshakes on input and output.

Parameters:
- W, 16, operand and result width; must be a multiple of C.
- C, 4, chunk width processed per cycle; number of chunks N = W/C.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present on a, b, bin.
- in_ready  output  1  block can accept operands.
- a  input  W  minuend.
- b  input  W  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  W  a - b - bin, modulo 2^W.
- bout  output  1  final borrow-out; 1 when the unsigned result is negative.
- ovf  output  1  signed overflow of a - b - bin.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is asynchronous and active-high; it forces state IDLE immediately.
  - Reset values: in_ready=0 while rst is high; out_valid=0, diff=0, bout=0, ovf=0, busy=0, chunk index=0, borrow register=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance on in_valid && in_ready at a rising edge: latch a, b; borrow register <= bin; idx <= 0; go to RUN.
  - in_valid without in_ready is ignored.
- RUN:
  - Each cycle, process chunk idx (bits idx*C+C-1 .. idx*C).
  - Per bit i: g_i = ~a_i & b_i; p_i = ~(a_i ^ b_i); br_{i+1} = g_i | (p_i & br_i); d_i = a_i ^ b_i ^ br_i; br_0 = borrow register.
  - Chunk result is written into diff at that chunk's position; borrow register <= br_C; idx <= idx+1.
  - After chunk N-1: bout <= final borrow; ovf <= (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]); go to DONE.
  - in_ready=0 throughout RUN.
- DONE:
  - out_valid=1; diff, bout and ovf held stable until out_ready.
  - out_valid && out_ready at an edge -> IDLE.
  - out_valid falls and in_ready rises in the next cycle. There is no same-cycle re-accept.
- Latency: out_valid rises exactly N cycles after the acceptance edge (N=4 at defaults).
- Throughput: one result per N+2 cycles minimum.
- Partial-result visibility: diff is updated chunk-wise during RUN and is not valid until out_valid.
- Operand stability: a, b, bin may change freely after acceptance because they are captured internally.
- Reset mid-RUN or mid-DONE:
  - The operation is abandoned and the result is lost.
  - After rst deasserts, the block is in IDLE with in_ready=1; no spurious out_valid.
- Degenerate N=1 (C=W): RUN lasts one cycle. Output is identical to a full-width lookahead subtract.
- The C-bit chunk index wraps never; its width is clog2(N) (minimum 1).

Decomposition:
- Shared package sub_pkg:
  - state typedef (IDLE, RUN, DONE);
  - helper function returning N and the index width from W and C.
- Sub-module borrow_lookahead_unit:
  - purely combinational, parameter C;
  - inputs bin, a_chunk, b_chunk; outputs d_chunk and bout_chunk;
  - implements the g/p borrow chain above.
- The FSM, chunk counter and result registers stay in the top module.

Test Plan:
- a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, ovf=0; out_valid exactly 4 cycles after acceptance.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Confirms the borrow ripples across all 4 chunk boundaries.
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
- a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1, ovf=0.
- Backpressure: out_ready held low 5 cycles with in_valid=1 and changing operands -> diff/bout/ovf stable, in_ready=0, no new acceptance. Then out_ready=1 for one edge -> out_valid=0 and in_ready=1 next cycle; the next operands are accepted.
- rst pulsed asynchronously (mid-cycle) during the 2nd RUN cycle -> out_valid, busy and diff go to 0 immediately. No out_valid after release; a fresh operation (a=0x0010, b=0x0001) yields 0x000F.
